ro_puf_challenge_sequencer: RTL and testbench
=============================================

Name: ro_puf_challenge_sequencer

Overview:
- Sequences an RO PUF majority-vote controller through NUM_CHALLENGES challenges and assembles one response bit per challenge into a word.
- For each challenge index it drives the challenge select, raises the controller's master enable and waits for its finished flag.
- It then captures the majority response, drops the enable for a guard gap, and moves to the next challenge.
- Sits between the system host (START/ABORT) and the PUF controller.

Parameters:
- NUM_CHALLENGES, 16, number of challenges per run; Response_word width.
- CHAL_W, 4, challenge index width; must satisfy 2^CHAL_W >= NUM_CHALLENGES.
- TIMEOUT_CYCLES, 1024, maximum cycles from launch to PUF_Finished before an error is raised.
- GAP_CYCLES, 4, minimum cycles PUF_EN_master is held low between challenges; legal minimum 3.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  begin a run; sampled in IDLE only.
- ABORT  in  1  cancel the current run from any state.
- PUF_Finished  in  1  controller finished flag, registered at the source.
- PUF_Response  in  1  controller majority response, registered at the source.
- PUF_busy  in  1  controller busy flag.
- PUF_EN_master  out  1  controller master enable.
- Challenge  out  CHAL_W  current challenge index.
- Response_word  out  NUM_CHALLENGES  collected responses; bit i holds the response for challenge i.
- Response_valid  out  1  Response_word is complete; sticky.
- Busy  out  1  run in progress.
- Timeout_err  out  1  last run aborted on timeout; sticky.

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, index 0, all counters 0.
- Registered outputs: every output is registered, changing one cycle after the state/condition that sets it.
- States: IDLE, GAP, LAUNCH, WAIT_DONE, CAPTURE, DONE.
- IDLE:
  - Busy=0, PUF_EN_master=0.
  - START=1 and ABORT=0 -> clear Response_word, Response_valid, Timeout_err; Challenge=0; gap counter=0; go to GAP.
  - Busy=1 from the next cycle.
- GAP:
  - PUF_EN_master=0; the gap counter increments each cycle.
  - Leave for LAUNCH when gap counter >= GAP_CYCLES-1 AND PUF_busy=0 AND PUF_Finished=0.
  - Otherwise stay. No timeout applies in GAP.
- LAUNCH: PUF_EN_master=1, timeout timer=0, go to WAIT_DONE. Challenge is stable for the whole time EN is high.
- WAIT_DONE:
  - PUF_EN_master=1; the timer increments each cycle.
  - PUF_Finished=1 -> CAPTURE.
  - Timer reaches TIMEOUT_CYCLES-1 with PUF_Finished=0 -> Timeout_err=1, PUF_EN_master=0, Busy=0, Response_valid stays 0, go to IDLE.
  - Timer width is clog2(TIMEOUT_CYCLES); the timer saturates and never wraps.
- CAPTURE:
  - PUF_EN_master stays 1 for this cycle.
  - Response_word[Challenge] <= PUF_Response, sampled one cycle after PUF_Finished is first seen so both source registers are settled.
  - If Challenge == NUM_CHALLENGES-1 -> DONE.
  - Else Challenge <= Challenge+1, gap counter=0, go to GAP.
  - PUF_EN_master=0 from the next cycle.
- DONE: Response_valid=1, Busy=0, go to IDLE. Response_valid holds until the next accepted START or an ABORT.
- ABORT=1 in any state:
  - Next cycle: IDLE, PUF_EN_master=0, Busy=0, Response_valid=0.
  - Response_word and Challenge hold their last values; Timeout_err is unchanged.
  - ABORT has priority over START and over every transition in the same cycle.
- START outside IDLE is ignored.
- Simultaneous PUF_Finished and timeout expiry in WAIT_DONE: Finished wins and the bit is captured.
- Asynchronous reset mid-run: PUF_EN_master drops immediately; nothing is retained.
- Per-challenge latency: GAP_CYCLES + 1 (LAUNCH) + controller time + 1 (CAPTURE) cycles, plus any PUF_busy stall.

Test Plan:
1. Reset: assert RST_N=0 mid-WAIT_DONE -> PUF_EN_master=0 without waiting for a CLK edge; all outputs 0 after release.
2. Normal run (NUM_CHALLENGES=4, GAP_CYCLES=4, PUF model returning 1,0,1,1) -> Challenge steps 0,1,2,3; EN low >=4 cycles between launches; Response_word=4'b1101; Response_valid=1 one cycle after the DONE transition; Busy=0.
3. Timeout (TIMEOUT_CYCLES=64, model never asserts Finished) -> Timeout_err=1 and PUF_EN_master=0 64 cycles after LAUNCH; Response_valid=0; Busy=0.
4. ABORT in WAIT_DONE on challenge 2 -> next cycle EN=0, Busy=0, Response_valid=0; a new START restarts at Challenge=0 with Response_word cleared.
5. Ordering: START pulsed while Busy=1 -> no effect. START+ABORT together in IDLE -> remains IDLE, Busy=0.
6. PUF_busy held high for 10 cycles in GAP -> LAUNCH is delayed until the cycle after PUF_busy falls; the captured bit is still correct.

Source files
------------

// File: rtl/ro_puf_challenge_sequencer.sv
// ro_puf_challenge_sequencer: steps an RO PUF majority-vote controller through NUM_CHALLENGES challenges, one response bit each
// Ports:
//   CLK, RST_N                      clock (rising edge), asynchronous active-low reset
//   START, ABORT                    host run request / cancel (ABORT wins)
//   PUF_Finished, PUF_Response      controller done flag and majority bit (registered at source)
//   PUF_busy                        controller busy; holds off the next launch
//   PUF_EN_master, Challenge        controller master enable and challenge select
//   Response_word, Response_valid   collected bits (bit i = challenge i), sticky completion flag
//   Busy, Timeout_err               run in progress, sticky timeout of the last run
module ro_puf_challenge_sequencer #(
  parameter int NUM_CHALLENGES = 16,
  parameter int CHAL_W = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      START,
  input  logic                      ABORT,
  input  logic                      PUF_Finished,
  input  logic                      PUF_Response,
  input  logic                      PUF_busy,
  output logic                      PUF_EN_master,
  output logic [CHAL_W-1:0]         Challenge,
  output logic [NUM_CHALLENGES-1:0] Response_word,
  output logic                      Response_valid,
  output logic                      Busy,
  output logic                      Timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [CHAL_W-1:0] C_LAST = CHAL_W'(NUM_CHALLENGES - 1);
  typedef enum logic [2:0] {IDLE, GAP, LAUNCH, WAIT_DONE, CAPTURE, DONE} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      timer <= '0;
      gap_cnt <= '0;
      PUF_EN_master <= 1'b0;
      Challenge <= '0;
      Response_word <= '0;
      Response_valid <= 1'b0;
      Busy <= 1'b0;
      Timeout_err <= 1'b0;
    end else if (ABORT) begin
      state <= IDLE;
      PUF_EN_master <= 1'b0;
      Busy <= 1'b0;
      Response_valid <= 1'b0;
    end else
      case (state)
        IDLE:
          if (START) begin
            Response_word <= '0;
            Response_valid <= 1'b0;
            Timeout_err <= 1'b0;
            Challenge <= '0;
            gap_cnt <= '0;
            Busy <= 1'b1;
            state <= GAP;
          end
        GAP: begin
          // counter saturates at its exit threshold so a long PUF_busy stall cannot wrap it
          if (gap_cnt < G_LAST) gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt >= G_LAST && !PUF_busy && !PUF_Finished) state <= LAUNCH;
        end
        LAUNCH: begin
          PUF_EN_master <= 1'b1;
          timer <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE:
          // Finished is tested first so it wins over a coincident expiry
          if (PUF_Finished) state <= CAPTURE;
          else if (timer == T_LAST) begin
            Timeout_err <= 1'b1;
            PUF_EN_master <= 1'b0;
            Busy <= 1'b0;
            state <= IDLE;
          end else timer <= timer + 1'b1;
        CAPTURE: begin
          // one cycle after Finished, so the response register at the source has settled
          Response_word[Challenge] <= PUF_Response;
          PUF_EN_master <= 1'b0;
          if (Challenge == C_LAST) state <= DONE;
          else begin
            Challenge <= Challenge + 1'b1;
            gap_cnt <= '0;
            state <= GAP;
          end
        end
        DONE: begin
          Response_valid <= 1'b1;
          Busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_ro_puf_challenge_sequencer.sv
// tb_ro_puf_challenge_sequencer: scoreboard bench for the challenge sequencer with a PUF controller model
module tb_ro_puf_challenge_sequencer;
  localparam int N = 4;
  localparam int CW = 2;
  localparam int TO = 64;
  localparam int GAP = 4;
  localparam int PUF_LAT = 6;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic START = 1'b0;
  logic ABORT = 1'b0;
  logic PUF_Finished = 1'b0;
  logic PUF_Response = 1'b0;
  logic PUF_busy = 1'b0;
  logic PUF_EN_master;
  logic [CW-1:0] Challenge;
  logic [N-1:0] Response_word;
  logic Response_valid;
  logic Busy;
  logic Timeout_err;
  ro_puf_challenge_sequencer #(.NUM_CHALLENGES(N), .CHAL_W(CW), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .PUF_Finished(PUF_Finished), .PUF_Response(PUF_Response), .PUF_busy(PUF_busy),
    .PUF_EN_master(PUF_EN_master), .Challenge(Challenge), .Response_word(Response_word),
    .Response_valid(Response_valid), .Busy(Busy), .Timeout_err(Timeout_err)
  );
  always #5 CLK = ~CLK;
  typedef struct {bit tmo; logic [N-1:0] word;} exp_t;
  exp_t exp_q[$];
  int chal_q[$];
  int n_checks = 0;
  int n_pass = 0;
  logic [N-1:0] puf_bits = '0;
  bit puf_hang = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // controller model: registered Finished/Response, PUF_LAT cycles after enable, cleared when enable drops
  initial begin
    int en_cnt;
    en_cnt = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (!PUF_EN_master) begin
        en_cnt = 0;
        PUF_Finished = 1'b0;
      end else begin
        en_cnt++;
        if (!puf_hang && en_cnt == PUF_LAT) begin
          PUF_Finished = 1'b1;
          PUF_Response = puf_bits[Challenge];
        end
      end
    end
  end
  // monitor: pops expectations when the DUT launches a challenge or presents a result
  initial begin
    logic en_d, val_d, terr_d;
    int high_cnt, low_cnt, c;
    exp_t e;
    en_d = 0; val_d = 0; terr_d = 0; high_cnt = 0; low_cnt = 100;
    forever begin
      @(negedge CLK);
      if (PUF_EN_master && !en_d) begin
        if (chal_q.size() == 0) chk("unexpected_launch", 1, 0);
        else begin
          c = chal_q.pop_front();
          chk("launch_challenge", 32'(Challenge), c);
          chk("gap_low_cycles_ok", 32'(low_cnt >= GAP), 1);
        end
      end
      if (PUF_EN_master) high_cnt = en_d ? high_cnt + 1 : 1;
      else low_cnt = en_d ? 1 : low_cnt + 1;
      if ((Response_valid && !val_d) || (Timeout_err && !terr_d)) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("result_kind_timeout", 32'(Timeout_err), 32'(e.tmo));
          chk("result_valid", 32'(Response_valid), 32'(!e.tmo));
          chk("result_busy", 32'(Busy), 0);
          chk("result_en", 32'(PUF_EN_master), 0);
          if (e.tmo) chk("timeout_en_high_cycles", high_cnt, TO);
          else chk("response_word", 32'(Response_word), 32'(e.word));
        end
      end
      en_d = PUF_EN_master;
      val_d = Response_valid;
      terr_d = Timeout_err;
    end
  end
  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask
  task automatic wait_valid(input string name);
    for (int i = 0; i < 400 && !Response_valid; i++) @(negedge CLK);
    chk(name, 32'(Response_valid), 1);
  endtask
  task automatic queue_run(input logic [N-1:0] bits);
    for (int i = 0; i < N; i++) chal_q.push_back(i);
    exp_q.push_back('{1'b0, bits});
  endtask
  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_outputs", 32'({PUF_EN_master, Challenge, Response_word, Response_valid, Busy, Timeout_err}), 0);
    RST_N = 1'b1;
    @(negedge CLK);
    // normal run, with a START pulse mid-run that must be ignored
    puf_bits = 4'b1101;
    queue_run(4'b1101);
    pulse_start();
    chk("busy_after_start", 32'(Busy), 1);
    for (int i = 0; i < 200 && !(PUF_EN_master && Challenge == 1); i++) @(negedge CLK);
    pulse_start();
    wait_valid("normal_run_done");
    repeat (3) @(negedge CLK);
    chk("valid_sticky", 32'({Response_valid, Busy}), 32'(2'b10));
    // START with ABORT in IDLE: stays idle, valid cleared, word held
    START = 1'b1;
    ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    ABORT = 1'b0;
    chk("start_abort_idle", 32'({Busy, Response_valid, PUF_EN_master}), 0);
    chk("abort_word_held", 32'(Response_word), 32'(4'b1101));
    repeat (5) @(negedge CLK);
    chk("still_idle", 32'({Busy, PUF_EN_master}), 0);
    // timeout: controller never finishes
    puf_hang = 1'b1;
    chal_q.push_back(0);
    exp_q.push_back('{1'b1, '0});
    pulse_start();
    for (int i = 0; i < 400 && !Timeout_err; i++) @(negedge CLK);
    chk("timeout_seen", 32'(Timeout_err), 1);
    chk("timeout_word_cleared", 32'({Challenge, Response_word}), 0);
    puf_hang = 1'b0;
    // ABORT while waiting on challenge 2
    for (int i = 0; i < 3; i++) chal_q.push_back(i);
    pulse_start();
    chk("start_clears_terr", 32'(Timeout_err), 0);
    for (int i = 0; i < 300 && !(PUF_EN_master && Challenge == 2); i++) @(negedge CLK);
    chk("reached_chal2", 32'(Challenge), 2);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("abort_outputs", 32'({PUF_EN_master, Busy, Response_valid, Timeout_err}), 0);
    chk("abort_holds", 32'({Challenge, Response_word}), 32'({2'd2, 4'b0001}));
    // restart after abort
    puf_bits = 4'b0110;
    queue_run(4'b0110);
    pulse_start();
    chk("restart_cleared", 32'({Busy, Challenge, Response_word}), 32'({1'b1, 2'd0, 4'b0000}));
    wait_valid("restart_done");
    // PUF_busy stall in GAP
    puf_bits = 4'b1011;
    queue_run(4'b1011);
    PUF_busy = 1'b1;
    pulse_start();
    repeat (9) @(negedge CLK);
    chk("stall_no_launch", 32'({PUF_EN_master, Busy}), 32'(2'b01));
    PUF_busy = 1'b0;
    @(negedge CLK);
    chk("stall_launch_cycle", 32'(PUF_EN_master), 0);
    @(negedge CLK);
    chk("stall_en_rises", 32'(PUF_EN_master), 1);
    wait_valid("stall_run_done");
    // asynchronous reset in WAIT_DONE
    chal_q.push_back(0);
    pulse_start();
    for (int i = 0; i < 100 && !PUF_EN_master; i++) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 chk("async_reset_en", 32'(PUF_EN_master), 0);
    @(negedge CLK);
    chk("async_reset_outputs", 32'({PUF_EN_master, Challenge, Response_word, Response_valid, Busy, Timeout_err}), 0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size() + chal_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
